ex_mul_unit: RTL and testbench

Iterative 64-bit multiplier for the execute stage of the RV64 pipeline. It reads a decoded multiply operation, with its operands and destination, straight from the ID/EX pipeline register outputs. While it computes, it holds `stall_out` high so the front end and ID/EX keep their contents. It returns a single-cycle completion with the result, the destination register and the write-enable for the EX/MEM boundary.

---
 rtl/ex_mul_unit.sv | 139 +++++++++++++
 tb/tb_ex_mul_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_unit.sv
// Iterative shift-add 64x64 multiplier for the RV64 execute stage.
// Stalls the front end while iterating and returns a one-cycle completion.
module ex_mul_unit #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] rs1Data_in,
  input  logic [XLEN-1:0] rs2Data_in,
  input  logic [4:0]      rd_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            RegWrite_out
);

  localparam int unsigned STEPS  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(STEPS + 1);
  localparam int unsigned ACC_W  = 2 * XLEN;
  localparam int unsigned PART_W = XLEN + BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  mul_op_e           op_q, op_dec;
  logic [CNT_W-1:0]  cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_q;
  logic [4:0]        rd_q;

  logic              accept;
  logic              last_step;
  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_abs, rs2_abs;
  logic [PART_W-1:0] partial;
  logic [PART_W-1:0] sum;
  logic [ACC_W-1:0]  acc_step;
  logic [ACC_W-1:0]  prod;

  // Operand magnitudes; MULHU never sign-interprets, MULHSU only rs1.
  always_comb begin
    op_dec  = mul_op_e'(op_in);
    rs1_neg = (op_dec != OP_MULHU) && rs1Data_in[XLEN-1];
    rs2_neg = ((op_dec == OP_MUL) || (op_dec == OP_MULH)) && rs2Data_in[XLEN-1];
    rs1_abs = rs1_neg ? (~rs1Data_in + 1'b1) : rs1Data_in;
    rs2_abs = rs2_neg ? (~rs2Data_in + 1'b1) : rs2Data_in;
  end

  // Upper half absorbs mcand * digit, then the whole accumulator shifts right;
  // after STEPS iterations it holds the unsigned product.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) partial = partial + (PART_W'(mcand_q) << i);
    end
    sum      = PART_W'(acc_q[ACC_W-1:XLEN]) + partial;
    acc_step = ACC_W'({sum, acc_q[XLEN-1:0]} >> BITS_PER_CYCLE);
    prod     = neg_q ? (~acc_step + 1'b1) : acc_step;
  end

  always_comb begin
    accept    = (state_q == S_IDLE) && start_in && !flush_in;
    last_step = (state_q == S_CALC) && (cnt_q == CNT_W'(1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_in) state_d = S_IDLE;
  end

  always_comb begin
    stall_out    = rst && ((accept) || (state_q == S_CALC));
    done_out     = (state_q == S_DONE) && !flush_in;
    RegWrite_out = done_out && (rd_out != 5'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OP_MUL;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      rd_q       <= '0;
      result_out <= '0;
      rd_out     <= '0;
    end else if (accept) begin
      op_q     <= op_dec;
      rd_q     <= rd_in;
      mcand_q  <= rs1_abs;
      mplier_q <= rs2_abs;
      neg_q    <= rs1_neg ^ rs2_neg;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(STEPS);
    end else if ((state_q == S_CALC) && !flush_in) begin
      acc_q    <= acc_step;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      cnt_q    <= cnt_q - 1'b1;
      if (last_step) begin
        result_out <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        rd_out     <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Scoreboard bench for ex_mul_unit: 1-bit/cycle and 4-bit/cycle instances.
module tb_ex_mul_unit;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        rw;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_in, flush_in;
  logic [1:0]  op;
  logic [63:0] rs1, rs2;
  logic [4:0]  rd;
  logic        stall, done, rw;
  logic [63:0] result;
  logic [4:0]  rd_o;

  logic        start4, flush4;
  logic [1:0]  op4;
  logic [63:0] a4, b4;
  logic [4:0]  rd4;
  logic        stall4, done4, rw4;
  logic [63:0] result4;
  logic [4:0]  rd_o4;

  int unsigned cyc = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned done_seen = 0;
  exp_t        q[$];
  exp_t        q4[$];

  ex_mul_unit #(.XLEN(64), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .op_in(op),
    .rs1Data_in(rs1), .rs2Data_in(rs2), .rd_in(rd), .flush_in(flush_in),
    .stall_out(stall), .done_out(done), .result_out(result),
    .rd_out(rd_o), .RegWrite_out(rw)
  );

  ex_mul_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start_in(start4), .op_in(op4),
    .rs1Data_in(a4), .rs2Data_in(b4), .rd_in(rd4), .flush_in(flush4),
    .stall_out(stall4), .done_out(done4), .result_out(result4),
    .rd_out(rd_o4), .RegWrite_out(rw4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ax, bx, p;
    ax = ((o != 2'b11) && a[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, a} : {64'h0, a};
    bx = ((o == 2'b00 || o == 2'b01) && b[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, b} : {64'h0, b};
    p  = ax * bx;
    return (o == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] r, input bit push, input logic [63:0] e);
    start_in = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
    if (push) q.push_back('{e, r, (r != 5'd0), cyc + 65});
  endtask

  task automatic drive4(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] r, input logic [63:0] e);
    start4 = 1'b1; op4 = o; a4 = a; b4 = b; rd4 = r;
    q4.push_back('{e, r, (r != 5'd0), cyc + 17});
  endtask

  task automatic wait_drain(input bit sel4, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((sel4 ? q4.size() : q.size()) == 0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_in = 1'b0; flush4 = 1'b0;
    drive_op(2'b00, 64'd7, 64'd6, 5'd5, 1'b0, 64'd0);
    start4 = 1'b1; op4 = 2'b00; a4 = 64'd2; b4 = 64'd3; rd4 = 5'd1;
    repeat (3) @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b expected 0", stall); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", done); end
    compared++; if (result !== 64'd0) begin mismatched++; $display("FAIL reset_result: got %h expected 0", result); end
    compared++; if (rd_o !== 5'd0) begin mismatched++; $display("FAIL reset_rd: got %0d expected 0", rd_o); end
    compared++; if (rw !== 1'b0) begin mismatched++; $display("FAIL reset_regwrite: got %b expected 0", rw); end
    compared++; if (stall4 !== 1'b0 || result4 !== 64'd0) begin mismatched++; $display("FAIL reset_b4: got stall=%b result=%h expected 0/0", stall4, result4); end
    tick();
    start_in = 1'b0; start4 = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_mul();
    int bad;
    bit ok;
    bad = 0;
    drive_op(2'b00, 64'd7, 64'd6, 5'd5, 1'b1, 64'd42);
    for (int k = 0; k <= 65; k++) begin
      @(negedge clk);
      if (stall !== (k <= 64)) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL basic_stall_window: got %0d wrong cycles expected 0", bad); end
    wait_drain(1'b0, 10, ok);
    start_in = 1'b0;
    compared++; if (!ok) begin mismatched++; $display("FAIL basic_timeout: got pending=%0d expected 0", q.size()); end
    @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL basic_idle_stall: got %b expected 0", stall); end
    tick();
  endtask

  task automatic test_signed_high();
    logic [1:0]  ops [8];
    logic [63:0] as  [8];
    logic [63:0] bs  [8];
    logic [63:0] es  [8];
    bit ok;
    ops[0] = 2'b01; as[0] = '1; bs[0] = '1; es[0] = 64'd0;
    ops[1] = 2'b00; as[1] = '1; bs[1] = '1; es[1] = 64'd1;
    ops[2] = 2'b11; as[2] = '1; bs[2] = '1; es[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    ops[3] = 2'b10; as[3] = '1; bs[3] = 64'd2; es[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 4; i < 8; i++) begin
      ops[i] = 2'($urandom_range(0, 3));
      as[i]  = {$urandom, $urandom};
      bs[i]  = {$urandom, $urandom};
      es[i]  = ref_mul(ops[i], as[i], bs[i]);
    end
    for (int i = 0; i < 8; i++) begin
      drive_op(ops[i], as[i], bs[i], 5'(i + 10), 1'b1, es[i]);
      wait_drain(1'b0, 80, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL signed_timeout_%0d: got pending=%0d expected 0", i, q.size()); end
    end
    start_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned seen0;
    bit ok;
    seen0 = done_seen;
    drive_op(2'b00, 64'd123456789, -64'sd3, 5'd9, 1'b1, -64'sd370370367);
    wait_drain(1'b0, 80, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_first_timeout: got pending=%0d expected 0", q.size()); end
    drive_op(2'b11, 64'h8000_0000_0000_0000, 64'd6, 5'd17, 1'b1, 64'd3);
    wait_drain(1'b0, 80, ok);
    start_in = 1'b0;
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_second_timeout: got pending=%0d expected 0", q.size()); end
    repeat (6) tick();
    compared++; if (done_seen - seen0 != 2) begin mismatched++; $display("FAIL b2b_done_count: got %0d expected 2", done_seen - seen0); end
  endtask

  task automatic test_flush();
    int unsigned seen0;
    int bad;
    seen0 = done_seen;
    drive_op(2'b00, 64'd1000, 64'd1000, 5'd3, 1'b0, 64'd0);
    repeat (10) tick();
    flush_in = 1'b1; start_in = 1'b0;
    tick();
    flush_in = 1'b0;
    @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL flush_stall: got %b expected 0", stall); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL flush_done: got %b expected 0", done); end
    compared++; if (result !== 64'd3) begin mismatched++; $display("FAIL flush_result_kept: got %h expected 3", result); end
    compared++; if (rd_o !== 5'd17) begin mismatched++; $display("FAIL flush_rd_kept: got %0d expected 17", rd_o); end
    tick();
    drive_op(2'b00, 64'd5, 64'd5, 5'd4, 1'b0, 64'd0);
    flush_in = 1'b1;
    @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL flush_idle_stall: got %b expected 0", stall); end
    tick();
    flush_in = 1'b0; start_in = 1'b0;
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (stall !== 1'b0) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL flush_idle_accepted: got %0d stalled cycles expected 0", bad); end
    compared++; if (done_seen != seen0) begin mismatched++; $display("FAIL flush_no_done: got %0d completions expected 0", done_seen - seen0); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    drive_op(2'b00, 64'd5, 64'd5, 5'd8, 1'b0, 64'd0);
    repeat (30) tick();
    rst = 1'b0;
    #1;
    compared++; if (result !== 64'd0) begin mismatched++; $display("FAIL midreset_result: got %h expected 0", result); end
    compared++; if (rd_o !== 5'd0) begin mismatched++; $display("FAIL midreset_rd: got %0d expected 0", rd_o); end
    compared++; if (done !== 1'b0 || rw !== 1'b0) begin mismatched++; $display("FAIL midreset_done: got done=%b rw=%b expected 0/0", done, rw); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL midreset_stall: got %b expected 0", stall); end
    tick();
    rst = 1'b1;
    drive_op(2'b00, 64'd3, 64'd3, 5'd7, 1'b1, 64'd9);
    wait_drain(1'b0, 80, ok);
    start_in = 1'b0;
    compared++; if (!ok) begin mismatched++; $display("FAIL midreset_timeout: got pending=%0d expected 0", q.size()); end
    tick();
  endtask

  task automatic test_rd0_b4();
    bit ok;
    logic [1:0]  o;
    logic [63:0] a, b;
    drive4(2'b00, 64'd2, 64'd3, 5'd0, 64'd6);
    wait_drain(1'b1, 30, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b4_rd0_timeout: got pending=%0d expected 0", q4.size()); end
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = (i == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      drive4(o, a, b, 5'($urandom_range(1, 31)), ref_mul(o, a, b));
      wait_drain(1'b1, 30, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL b4_rand_timeout_%0d: got pending=%0d expected 0", i, q4.size()); end
    end
    start4 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    fork
      forever begin : mon1
        exp_t e;
        @(negedge clk);
        if (rst === 1'b1 && done === 1'b1) begin
          done_seen++;
          if (q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_done: got done_out=1 at cycle %0d expected none", cyc);
          end else begin
            e = q.pop_front();
            compared++; if (result !== e.res) begin mismatched++; $display("FAIL result: got %h expected %h", result, e.res); end
            compared++; if (rd_o !== e.rd) begin mismatched++; $display("FAIL rd_out: got %0d expected %0d", rd_o, e.rd); end
            compared++; if (rw !== e.rw) begin mismatched++; $display("FAIL regwrite: got %b expected %b", rw, e.rw); end
            compared++; if (cyc != e.cyc) begin mismatched++; $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc); end
          end
        end
      end
      forever begin : mon4
        exp_t e4;
        @(negedge clk);
        if (rst === 1'b1 && done4 === 1'b1) begin
          if (q4.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL b4_unexpected_done: got done_out=1 at cycle %0d expected none", cyc);
          end else begin
            e4 = q4.pop_front();
            compared++; if (result4 !== e4.res) begin mismatched++; $display("FAIL b4_result: got %h expected %h", result4, e4.res); end
            compared++; if (rd_o4 !== e4.rd) begin mismatched++; $display("FAIL b4_rd_out: got %0d expected %0d", rd_o4, e4.rd); end
            compared++; if (rw4 !== e4.rw) begin mismatched++; $display("FAIL b4_regwrite: got %b expected %b", rw4, e4.rw); end
            compared++; if (cyc != e4.cyc) begin mismatched++; $display("FAIL b4_done_cycle: got %0d expected %0d", cyc, e4.cyc); end
          end
        end
      end
    join_none

    test_reset();
    test_basic_mul();
    test_signed_high();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    test_rd0_b4();

    repeat (4) tick();
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL pending_b1: got %0d expected 0", q.size()); end
    compared++; if (q4.size() != 0) begin mismatched++; $display("FAIL pending_b4: got %0d expected 0", q4.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
